// File: rtl/idex_pipe_stage.sv
// ID->EX pipeline stage: valid/ready handshake, flush, ALU operand select.
// Define IDEX_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module idex_pipe_stage #(
  parameter int WordSize = 32,
  parameter int RegBits  = 5,
  parameter int LuiShift = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          a_sel,
  input  logic [1:0]          b_sel,
  input  logic [WordSize-1:0] pc_in,
  input  logic [WordSize-1:0] imm,
  input  logic [WordSize-1:0] rs1d,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic                branch_taken_in,
  input  logic [RegBits-1:0]  rdn_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] a,
  output logic [WordSize-1:0] b,
  output logic [WordSize-1:0] rs2d,
  output logic [WordSize-1:0] branch_addr,
  output logic [RegBits-1:0]  rdn,
  output logic                branch_taken
);

  localparam int PW = 5 * WordSize + RegBits + 1;

  logic [WordSize-1:0] w_a;
  logic [WordSize-1:0] w_b;
  logic [PW-1:0]       w_in_pl;
  logic                w_push;
  logic                w_pop;

  logic [PW-1:0]       r_out_pl;
  logic                r_out_valid;

  always_comb begin
    w_a = '0;
    unique case (a_sel)
      2'd0:    w_a = rs1d;
      2'd1:    w_a = pc_in;
      default: w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    unique case (b_sel)
      2'd0:    w_b = rs2d_in;
      2'd1:    w_b = imm;
      2'd2:    w_b = WordSize'(4);
      default: w_b = imm << LuiShift;
    endcase
  end

  assign w_in_pl = {pc_in, w_a, w_b, rs2d_in,
                    branch_addr_in, rdn_in,
                    branch_taken_in};

  assign {pc, a, b, rs2d, branch_addr,
          rdn, branch_taken} = r_out_pl;

  assign out_valid = r_out_valid;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = r_out_valid & out_ready;

`ifdef IDEX_SKID_EN
  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_skid_pl;
  logic          r_in_ready;

  assign in_ready = r_in_ready;

  // Payload regs survive flush; only the state and valid flags clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_pl    <= '0;
      r_skid_pl   <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_out_pl    <= w_in_pl;
            r_out_valid <= 1'b1;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_push && w_pop) begin
            r_out_pl <= w_in_pl;
          end else if (w_push) begin
            r_skid_pl  <= w_in_pl;
            r_in_ready <= 1'b0;
            r_state    <= SKID;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        SKID: begin
          if (w_pop) begin
            r_out_pl   <= r_skid_pl;
            r_in_ready <= 1'b1;
            r_state    <= FULL;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= EMPTY;
        end
      endcase
    end
  end
`else
  assign in_ready = !r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pl    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_push) begin
      r_out_pl    <= w_in_pl;
      r_out_valid <= 1'b1;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Bench for idex_pipe_stage: scoreboard of captured payloads vs outputs.
// Works with and without IDEX_SKID_EN defined.
module tb_idex_pipe_stage;

  localparam int W  = 32;
  localparam int RB = 5;
  localparam int PW = 5 * W + RB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    a_sel = '0;
  logic [1:0]    b_sel = '0;
  logic [W-1:0]  pc_in = '0;
  logic [W-1:0]  imm = '0;
  logic [W-1:0]  rs1d = '0;
  logic [W-1:0]  rs2d_in = '0;
  logic [W-1:0]  branch_addr_in = '0;
  logic          branch_taken_in = 1'b0;
  logic [RB-1:0] rdn_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  pc, a, b, rs2d, branch_addr;
  logic [RB-1:0] rdn;
  logic          branch_taken;

  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [PW-1:0] q[$];
  logic [PW-1:0] w_outvec;

  assign w_outvec = {pc, a, b, rs2d, branch_addr,
                     rdn, branch_taken};

  idex_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sel(a_sel), .b_sel(b_sel),
    .pc_in(pc_in), .imm(imm), .rs1d(rs1d),
    .rs2d_in(rs2d_in),
    .branch_addr_in(branch_addr_in),
    .branch_taken_in(branch_taken_in),
    .rdn_in(rdn_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .a(a), .b(b), .rs2d(rs2d),
    .branch_addr(branch_addr), .rdn(rdn),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_a(
    input logic [1:0] s, input logic [W-1:0] r1,
    input logic [W-1:0] p);
    case (s)
      2'd0:    return r1;
      2'd1:    return p;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] f_b(
    input logic [1:0] s, input logic [W-1:0] r2,
    input logic [W-1:0] im);
    logic [W-1:0] sh;
    sh = {im[W-13:0], 12'h000};
    case (s)
      2'd0:    return r2;
      2'd1:    return im;
      2'd2:    return 32'd4;
      default: return sh;
    endcase
  endfunction

  // Scoreboard: push on input transfer, pop on output transfer.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got=%h", w_outvec);
        end else begin
          e = q.pop_front();
          if (w_outvec !== e) begin
            n_err++;
            $display("FAIL sb_payload got=%h exp=%h",
                     w_outvec, e);
          end
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        n_push++;
        q.push_back({pc_in,
                     f_a(a_sel, rs1d, pc_in),
                     f_b(b_sel, rs2d_in, imm),
                     rs2d_in, branch_addr_in,
                     rdn_in, branch_taken_in});
      end
    end
  end

  task automatic drive(input logic v,
                       input logic [RB-1:0] rd);
    in_valid        = v;
    rdn_in          = rd;
    pc_in           = $urandom;
    imm             = $urandom;
    rs1d            = $urandom;
    rs2d_in         = $urandom;
    branch_addr_in  = $urandom;
    branch_taken_in = 1'($urandom);
    a_sel           = 2'($urandom);
    b_sel           = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    n_cmp++;
    if ({a, b, pc, rdn} !== '0) begin
      n_err++;
      $display("FAIL rst_payload got=%h exp=0",
               {a, b, pc, rdn});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after got=%b%b exp=10",
               in_ready, out_valid);
    end
  endtask

  task automatic test_operands();
    @(posedge clk); #1;
    drive(1'b1, 5'd3);
    rs1d = 32'h10; pc_in = 32'h400; imm = 32'h5;
    a_sel = 2'd1; b_sel = 2'd3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 5'd4);
    rs1d = 32'h10; pc_in = 32'h800; imm = 32'h5;
    a_sel = 2'd0; b_sel = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || a !== 32'h400 ||
        b !== 32'h5000) begin
      n_err++;
      $display("FAIL op_pc_lui got v=%b a=%h b=%h exp 1/400/5000",
               out_valid, a, b);
    end
    @(posedge clk); #1;
    drive(1'b0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || a !== 32'h10 ||
        b !== 32'h4) begin
      n_err++;
      $display("FAIL op_rs1_four got v=%b a=%h b=%h exp 1/10/4",
               out_valid, a, b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int idx = 0;
    int occ = 0;
    int got[$];
    logic held = 1'b0;
    logic [PW-1:0] hold = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      drive(idx < 3, RB'(idx + 1));
      out_ready = !(c == 1 || c == 2);
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (w_outvec !== hold) begin
          n_err++;
          $display("FAIL stall_hold got=%h exp=%h",
                   w_outvec, hold);
        end
      end
`ifdef IDEX_SKID_EN
      n_cmp++;
      if (in_ready !== (occ < 2)) begin
        n_err++;
        $display("FAIL stall_in_ready got=%b exp=%b",
                 in_ready, occ < 2);
      end
`endif
      if (out_valid && out_ready) begin
        got.push_back(int'(rdn));
        occ--;
      end
      if (in_valid && in_ready) begin
        idx++;
        occ++;
      end
      held = out_valid && !out_ready;
      hold = w_outvec;
    end
    n_cmp++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL stall_count got=%0d exp=3",
               got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++;
      if (got[i] != i + 1) begin
        n_err++;
        $display("FAIL stall_order[%0d] got=%0d exp=%0d",
                 i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    drive(1'b1, 5'h0A);
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 5'h1F);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_empty got=%b%b exp=01",
               out_valid, in_ready);
    end
    n_cmp++;
    if (rdn !== 5'h0A) begin
      n_err++;
      $display("FAIL flush_keep got=%h exp=0a", rdn);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_ghost got=%b exp=0",
                 out_valid);
      end
    end
`ifdef IDEX_SKID_EN
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(1'b1, RB'(i + 11));
      out_ready = 1'b0;
    end
    @(posedge clk); #1;
    drive(1'b1, 5'h1E);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_skid got=%b%b exp=01",
               out_valid, in_ready);
    end
`endif
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, RB'(i + 4));
      out_ready = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'h1D);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 5'h15);
    rs1d = 32'hABCD;
    a_sel = 2'd0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_empty got=%b%b exp=01",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || rdn !== 5'h15 ||
        a !== 32'hABCD) begin
      n_err++;
      $display("FAIL midrst_next got v=%b rdn=%h a=%h exp 1/15/abcd",
               out_valid, rdn, a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    int p0 = n_push;
    int o0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      drive(1'b1, RB'($urandom));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    drive(1'b0, 5'd0);
    @(posedge clk); #1;
    n_cmp++;
    if (n_push - p0 != 100) begin
      n_err++;
      $display("FAIL tput_in got=%0d exp=100",
               n_push - p0);
    end
    n_cmp++;
    if (n_pop - o0 != 100) begin
      n_err++;
      $display("FAIL tput_out got=%0d exp=100",
               n_pop - o0);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL tput_left got=%0d exp=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_operands();
    test_stall();
    test_flush();
    test_reset_midop();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
